// File: rtl/hacd_pkg.sv
// Shared types and constants for the hacd_core table-init path and the AXI write master.
// Pure declarations; no logic.
// Packet structs are the contract between hawk_tbl_init_wr and hacd_axi_master.
package hacd_pkg;

  localparam int          AXI_ADDR_W       = 64;
  localparam int          LINE_BYTES       = 64;
  localparam int          ENTRIES_PER_LINE = 8;
  localparam logic [31:0] NULL_IDX         = 32'd0;

  // One cacheline write request toward the AXI master
  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [511:0]          data;
    logic [63:0]           strb;
    logic                  awvalid;
    logic                  wvalid;
  } axi_wr_reqpkt_t;

  // Per-channel accept back from the AXI master
  typedef struct packed {
    logic awready;
    logic wready;
  } axi_wr_rdypkt_t;

  // Free-list node; indices are 1-based, NULL_IDX terminates
  typedef struct packed {
    logic [31:0] next;
    logic [31:0] prev;
  } list_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ATT_WR,
    ST_LIST_WR
  } init_state_e;

endpackage

// File: rtl/hawk_list_line_gen.sv
// Builds one 512-bit free-list cacheline (8 doubly linked entries) from a line index.
// Purely combinational, zero latency.
// No flow control; the caller holds line_idx stable while the line is in flight.
module hawk_list_line_gen
  import hacd_pkg::*;
#(
  parameter int NUM_ENTRIES = 4096,
  parameter int LIDX_W      = 9
) (
  input  logic [LIDX_W-1:0] line_idx,
  output logic [511:0]      line
);

  logic [31:0] idx;
  list_entry_t ent;

  // Slot k holds entry line_idx*8+k+1, linked to its neighbours; the last entry ends the chain
  always_comb begin
    line = '0;
    idx  = '0;
    ent  = '0;
    for (int k = 0; k < ENTRIES_PER_LINE; k++) begin
      idx      = 32'(line_idx) * 32'(ENTRIES_PER_LINE) + 32'(k) + 32'd1;
      ent.prev = idx - 32'd1;
      ent.next = (idx == 32'(NUM_ENTRIES)) ? NULL_IDX : idx + 32'd1;
      line[64*k +: 64] = ent;
    end
  end

endmodule

// File: rtl/hawk_tbl_init_wr.sv
// Bulk-writes the ATT (all zero) or the free list (linked entries), one cacheline per transfer.
// Valids rise one cycle after the request edge; one line per cycle with readies held high.
// Each AXI channel waits independently on its ready; the next line issues only after both accept.
module hawk_tbl_init_wr
  import hacd_pkg::*;
#(
  parameter int                ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] ATT_BASE    = 64'h8000_0000,
  parameter logic [ADDR_W-1:0] LIST_BASE   = 64'h8010_0000,
  parameter int                NUM_ENTRIES = 4096
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           init_att,
  input  logic           init_list,
  output logic           init_att_done,
  output logic           init_list_done,
  output axi_wr_reqpkt_t wr_reqpkt,
  input  axi_wr_rdypkt_t wr_rdypkt
);

  localparam int NUM_LINES = NUM_ENTRIES / ENTRIES_PER_LINE;
  localparam int LIDX_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NUM_LINES - 1);

  init_state_e       state;
  logic [LIDX_W-1:0] line_idx;
  logic              init_att_q, init_list_q;
  logic              pend_att, pend_list;
  logic              awvalid, wvalid;
  logic              aw_done, w_done;
  logic              att_edge, list_edge;
  logic              aw_acc, w_acc, aw_fin, w_fin;
  logic [ADDR_W-1:0] line_addr;
  logic [511:0]      list_line;

  assign att_edge  = init_att & ~init_att_q;
  assign list_edge = init_list & ~init_list_q;
  assign aw_acc    = awvalid & wr_rdypkt.awready;
  assign w_acc     = wvalid & wr_rdypkt.wready;
  assign aw_fin    = aw_done | aw_acc;
  assign w_fin     = w_done | w_acc;

  hawk_list_line_gen #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .LIDX_W      (LIDX_W)
  ) u_line_gen (
    .line_idx (line_idx),
    .line     (list_line)
  );

  // Request edge capture, operation sequencing and per-line two-channel handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ST_IDLE;
      line_idx       <= '0;
      init_att_q     <= 1'b0;
      init_list_q    <= 1'b0;
      pend_att       <= 1'b0;
      pend_list      <= 1'b0;
      awvalid        <= 1'b0;
      wvalid         <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      init_att_done  <= 1'b0;
      init_list_done <= 1'b0;
    end else begin
      init_att_q  <= init_att;
      init_list_q <= init_list;
      pend_att    <= pend_att | att_edge;
      pend_list   <= pend_list | list_edge;
      case (state)
        ST_IDLE: begin
          if (pend_att | att_edge) begin
            state         <= ST_ATT_WR;
            pend_att      <= 1'b0;
            init_att_done <= 1'b0;
            line_idx      <= '0;
            awvalid       <= 1'b1;
            wvalid        <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
          end else if (pend_list | list_edge) begin
            state          <= ST_LIST_WR;
            pend_list      <= 1'b0;
            init_list_done <= 1'b0;
            line_idx       <= '0;
            awvalid        <= 1'b1;
            wvalid         <= 1'b1;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
          end
        end
        ST_ATT_WR, ST_LIST_WR: begin
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (line_idx == LAST_IDX) begin
              state   <= ST_IDLE;
              awvalid <= 1'b0;
              wvalid  <= 1'b0;
              if (state == ST_ATT_WR) init_att_done  <= 1'b1;
              else                    init_list_done <= 1'b1;
            end else begin
              line_idx <= line_idx + LIDX_W'(1);
              awvalid  <= 1'b1;
              wvalid   <= 1'b1;
            end
          end else begin
            if (aw_acc) begin
              awvalid <= 1'b0;
              aw_done <= 1'b1;
            end
            if (w_acc) begin
              wvalid <= 1'b0;
              w_done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign line_addr = ((state == ST_LIST_WR) ? LIST_BASE : ATT_BASE)
                   + (ADDR_W'(line_idx) * ADDR_W'(LINE_BYTES));

  // Drive the request packet; payload is zero whenever no table is being written
  always_comb begin
    wr_reqpkt         = '0;
    wr_reqpkt.awvalid = awvalid;
    wr_reqpkt.wvalid  = wvalid;
    if (state != ST_IDLE) begin
      wr_reqpkt.addr = AXI_ADDR_W'(line_addr);
      wr_reqpkt.strb = '1;
      wr_reqpkt.data = (state == ST_LIST_WR) ? list_line : '0;
    end
  end

endmodule

// File: tb/tb_hawk_tbl_init_wr.sv
// Scoreboard bench for hawk_tbl_init_wr with NUM_ENTRIES=16 (two lines per table).
// Expected lines are queued when a request is driven and compared at each channel accept.
// Cycle-level checks cover latency, backpressure, ordering, held requests and mid-op reset.
module tb_hawk_tbl_init_wr;
  import hacd_pkg::*;

  localparam int NE = 16;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] data;
  } exp_line_t;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           init_att = 1'b0;
  logic           init_list = 1'b0;
  logic           init_att_done, init_list_done;
  axi_wr_reqpkt_t wr_reqpkt;
  axi_wr_rdypkt_t wr_rdypkt;

  exp_line_t exp_q[$];
  int        n_chk = 0;
  int        n_pass = 0;
  int        lines_done = 0;
  logic      aw_seen = 1'b0;
  logic      w_seen = 1'b0;

  hawk_tbl_init_wr #(.NUM_ENTRIES(NE)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .init_att       (init_att),
    .init_list      (init_list),
    .init_att_done  (init_att_done),
    .init_list_done (init_list_done),
    .wr_reqpkt      (wr_reqpkt),
    .wr_rdypkt      (wr_rdypkt)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [511:0] list_line(input int li);
    logic [511:0] l;
    int           e;
    int           nx;
    l = '0;
    for (int k = 0; k < 8; k++) begin
      e  = li * 8 + k + 1;
      nx = (e == NE) ? 0 : e + 1;
      l[64*k +: 64] = {32'(nx), 32'(e - 1)};
    end
    return l;
  endfunction

  task automatic push_att();
    for (int li = 0; li < NE / 8; li++)
      exp_q.push_back('{addr: 64'h8000_0000 + 64'(li * 64), data: '0});
  endtask

  task automatic push_list();
    for (int li = 0; li < NE / 8; li++)
      exp_q.push_back('{addr: 64'h8010_0000 + 64'(li * 64), data: list_line(li)});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk("drain", 512'(exp_q.size()), 512'd0);
  endtask

  // Scoreboard: compare each channel's payload at its accept, retire the line when both are in
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      aw_seen = 1'b0;
      w_seen  = 1'b0;
    end else begin
      if (wr_reqpkt.awvalid && wr_rdypkt.awready) begin
        chk("aw_expected", 512'(exp_q.size() != 0), 512'd1);
        if (exp_q.size() != 0) begin
          chk("addr", 512'(wr_reqpkt.addr), 512'(exp_q[0].addr));
          chk("strb", 512'(wr_reqpkt.strb), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        end
        aw_seen = 1'b1;
      end
      if (wr_reqpkt.wvalid && wr_rdypkt.wready) begin
        chk("w_expected", 512'(exp_q.size() != 0), 512'd1);
        if (exp_q.size() != 0) chk("data", wr_reqpkt.data, exp_q[0].data);
        w_seen = 1'b1;
      end
      if (aw_seen && w_seen) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        lines_done++;
        aw_seen = 1'b0;
        w_seen  = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    logic act;
    wr_rdypkt = '{awready: 1'b1, wready: 1'b1};

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_awvalid", 512'(wr_reqpkt.awvalid), 512'd0);
    chk("rst_wvalid", 512'(wr_reqpkt.wvalid), 512'd0);
    chk("rst_addr", 512'(wr_reqpkt.addr), 512'd0);
    chk("rst_att_done", 512'(init_att_done), 512'd0);
    chk("rst_list_done", 512'(init_list_done), 512'd0);
    tick();
    rst_ni = 1'b1;
    repeat (2) tick();

    // ATT init, readies high: two back-to-back lines then done
    push_att();
    init_att = 1'b1;
    tick();
    init_att = 1'b0;
    @(negedge clk_i);
    chk("att_l0_vld", 512'({wr_reqpkt.awvalid, wr_reqpkt.wvalid}), 512'd3);
    chk("att_l0_addr", 512'(wr_reqpkt.addr), 512'(64'h8000_0000));
    chk("att_l0_done", 512'(init_att_done), 512'd0);
    @(negedge clk_i);
    chk("att_l1_vld", 512'({wr_reqpkt.awvalid, wr_reqpkt.wvalid}), 512'd3);
    chk("att_l1_addr", 512'(wr_reqpkt.addr), 512'(64'h8000_0040));
    chk("att_l1_done", 512'(init_att_done), 512'd0);
    @(negedge clk_i);
    chk("att_end_vld", 512'({wr_reqpkt.awvalid, wr_reqpkt.wvalid}), 512'd0);
    chk("att_done", 512'(init_att_done), 512'd1);
    chk("att_drain", 512'(exp_q.size()), 512'd0);

    // List init: linked entries, null at both ends
    tick();
    push_list();
    init_list = 1'b1;
    tick();
    init_list = 1'b0;
    @(negedge clk_i);
    chk("list_l0_s0", 512'(wr_reqpkt.data[63:0]), 512'(64'h0000_0002_0000_0000));
    @(negedge clk_i);
    chk("list_l1_s7", 512'(wr_reqpkt.data[511:448]), 512'(64'h0000_0000_0000_000F));
    chk("list_l1_addr", 512'(wr_reqpkt.addr), 512'(64'h8010_0040));
    @(negedge clk_i);
    chk("list_done", 512'(init_list_done), 512'd1);
    chk("list_drain", 512'(exp_q.size()), 512'd0);

    // Backpressure on the address channel only
    tick();
    wr_rdypkt = '{awready: 1'b0, wready: 1'b1};
    push_att();
    init_att = 1'b1;
    tick();
    init_att = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_awvalid", 512'(wr_reqpkt.awvalid), 512'd1);
      chk("bp_addr", 512'(wr_reqpkt.addr), 512'(64'h8000_0000));
      if (i >= 1) chk("bp_wvalid", 512'(wr_reqpkt.wvalid), 512'd0);
    end
    tick();
    wr_rdypkt = '{awready: 1'b1, wready: 1'b1};
    @(negedge clk_i);
    chk("bp_l0_still", 512'({wr_reqpkt.awvalid, wr_reqpkt.wvalid}), 512'd2);
    @(negedge clk_i);
    chk("bp_l1_vld", 512'({wr_reqpkt.awvalid, wr_reqpkt.wvalid}), 512'd3);
    chk("bp_l1_addr", 512'(wr_reqpkt.addr), 512'(64'h8000_0040));
    @(negedge clk_i);
    chk("bp_done", 512'(init_att_done), 512'd1);

    // Simultaneous requests: ATT first, one idle cycle, then list
    tick();
    push_att();
    push_list();
    init_att  = 1'b1;
    init_list = 1'b1;
    tick();
    init_att  = 1'b0;
    init_list = 1'b0;
    @(negedge clk_i);
    chk("sim_a0_addr", 512'(wr_reqpkt.addr), 512'(64'h8000_0000));
    chk("sim_a0_done", 512'(init_att_done), 512'd0);
    @(negedge clk_i);
    chk("sim_a1_addr", 512'(wr_reqpkt.addr), 512'(64'h8000_0040));
    @(negedge clk_i);
    chk("sim_gap_vld", 512'({wr_reqpkt.awvalid, wr_reqpkt.wvalid}), 512'd0);
    chk("sim_gap_att_done", 512'(init_att_done), 512'd1);
    @(negedge clk_i);
    chk("sim_l0_addr", 512'(wr_reqpkt.addr), 512'(64'h8010_0000));
    chk("sim_l0_list_done", 512'(init_list_done), 512'd0);
    @(negedge clk_i);
    chk("sim_l1_addr", 512'(wr_reqpkt.addr), 512'(64'h8010_0040));
    @(negedge clk_i);
    chk("sim_list_done", 512'(init_list_done), 512'd1);
    chk("sim_att_done_kept", 512'(init_att_done), 512'd1);
    chk("sim_drain", 512'(exp_q.size()), 512'd0);

    // Held-high request runs once; a fresh edge reruns it
    tick();
    base = lines_done;
    push_att();
    init_att = 1'b1;
    repeat (50) tick();
    chk("held_lines", 512'(lines_done - base), 512'd2);
    chk("held_done", 512'(init_att_done), 512'd1);
    init_att = 1'b0;
    tick();
    push_att();
    init_att = 1'b1;
    tick();
    @(negedge clk_i);
    chk("rerun_clr_done", 512'(init_att_done), 512'd0);
    wait_empty(20);
    @(negedge clk_i);
    chk("rerun_done", 512'(init_att_done), 512'd1);
    chk("rerun_lines", 512'(lines_done - base), 512'd4);
    init_att = 1'b0;
    tick();

    // Reset after the first list line: outputs drop at once, no resume
    push_list();
    init_list = 1'b1;
    tick();
    init_list = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_l0", 512'(wr_reqpkt.awvalid), 512'd1);
    tick();
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_vld", 512'({wr_reqpkt.awvalid, wr_reqpkt.wvalid}), 512'd0);
    chk("rst_mid_addr", 512'(wr_reqpkt.addr), 512'd0);
    chk("rst_mid_done", 512'({init_att_done, init_list_done}), 512'd0);
    exp_q.delete();
    repeat (3) tick();
    rst_ni = 1'b1;
    act = 1'b0;
    base = lines_done;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      act = act | wr_reqpkt.awvalid | wr_reqpkt.wvalid;
    end
    chk("no_resume", 512'(act), 512'd0);
    chk("no_resume_lines", 512'(lines_done - base), 512'd0);
    chk("post_rst_done", 512'({init_att_done, init_list_done}), 512'd0);
    tick();
    push_att();
    init_att = 1'b1;
    tick();
    init_att = 1'b0;
    wait_empty(20);
    @(negedge clk_i);
    chk("post_rst_att_done", 512'(init_att_done), 512'd1);
    chk("post_rst_list_done", 512'(init_list_done), 512'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
